// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and constants for the UART transmit/receive path.
//             Holds the FSM state type, default widths and the stop-bit
//             normalisation helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int         UART_DATA_BITS = 8;
  localparam int         UART_CBP_W     = 16;
  localparam logic [1:0] STOP_DEFAULT   = 2'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // A stop count of zero is not a legal frame; fall back to one stop bit.
  function automatic logic [1:0] eff_stop(input logic [1:0] stop_bits);
    return (stop_bits == 2'd0) ? STOP_DEFAULT : stop_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_engine_if
//  Purpose  : Bundle between the UART register block and the TX engine.
//  Signals  : cbp_i       clocks per bit          (register block -> engine)
//             stop_bits_i stop-bit count          (register block -> engine)
//             tx_data_i   byte to send            (register block -> engine)
//             tx_start_i  cfg start bit           (register block -> engine)
//             tx_o        serial line             (engine -> outside)
//             tx_busy_o   frame in progress       (engine -> register block)
//             tx_done_o   sticky frame-done flag  (engine -> register block)
//  Modports : master = register block side, slave = engine side
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_engine_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int CBP_W     = UART_CBP_W
);
  logic [CBP_W-1:0]     cbp_i;
  logic [1:0]           stop_bits_i;
  logic [DATA_BITS-1:0] tx_data_i;
  logic                 tx_start_i;
  logic                 tx_o;
  logic                 tx_busy_o;
  logic                 tx_done_o;

  modport master (
    output cbp_i, stop_bits_i, tx_data_i, tx_start_i,
    input  tx_o, tx_busy_o, tx_done_o
  );

  modport slave (
    input  cbp_i, stop_bits_i, tx_data_i, tx_start_i,
    output tx_o, tx_busy_o, tx_done_o
  );
endinterface
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_cnt
//  Purpose  : Loadable bit-period down-counter. Ticks while at zero and
//             reloads on the same edge, so consecutive bit periods butt up
//             against each other with no drift.
//  Ports    : clk_i      system clock
//             rst_i      synchronous active-high reset
//             en_i       count enable
//             load_i     load load_val_i (wins over counting)
//             load_val_i reload value (clocks per bit minus one)
//             tick_o     high on the last cycle of a bit period
//  Revision : 1.0 - initial release
// ============================================================================
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CNT_W = UART_CBP_W
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic             en_i,
  input  wire logic             load_i,
  input  wire logic [CNT_W-1:0] load_val_i,
  output logic                  tick_o
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (en_i) begin
      if (r_cnt == '0) begin
        r_cnt <= load_val_i;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign tick_o = en_i & (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_engine
//  Purpose  : UART serial transmitter, LSB first, 8N1..8N3 framing. A rising
//             edge on tx_start_i in IDLE latches the frame settings and sends
//             one frame; tx_done_o is a sticky completion flag.
//  Ports    : clk_i  system clock
//             rst_i  synchronous active-high reset (also aborts a frame)
//             bus    uart_tx_engine_if.slave (cbp, stop bits, data, start in;
//                    tx line, busy, done out)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int CBP_W     = UART_CBP_W
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  uart_tx_engine_if.slave bus
);

  localparam int             IDX_W      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DATA_BITS - 1);

  tx_state_t            r_state;
  logic                 r_start_q;
  logic [CBP_W-1:0]     r_cbp;
  logic [1:0]           r_stop;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [1:0]           r_stop_cnt;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_req;
  logic                 w_accept;
  logic [CBP_W-1:0]     w_cbp_in;
  logic [CBP_W-1:0]     w_load_val;
  logic                 w_tick;

  assign w_req    = bus.tx_start_i & ~r_start_q;
  assign w_accept = w_req & (r_state == IDLE);
  assign w_cbp_in = (bus.cbp_i == '0) ? CBP_W'(1) : bus.cbp_i;

  // On the accept cycle the shadow register is not yet loaded, so the
  // counter takes its first period straight from the input.
  assign w_load_val = w_accept ? (w_cbp_in - CBP_W'(1)) : (r_cbp - CBP_W'(1));

  uart_baud_cnt #(
    .CNT_W (CBP_W)
  ) u_baud_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (r_state != IDLE),
    .load_i     (w_accept),
    .load_val_i (w_load_val),
    .tick_o     (w_tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_start_q  <= 1'b0;
      r_cbp      <= '0;
      r_stop     <= '0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_start_q <= bus.tx_start_i;
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_accept) begin
            r_cbp      <= w_cbp_in;
            r_stop     <= eff_stop(bus.stop_bits_i);
            r_shift    <= bus.tx_data_i;
            r_bit_idx  <= '0;
            r_stop_cnt <= '0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_state    <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_idx == c_last_idx) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_stop_cnt == (r_stop - 2'd1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_tx    <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_stop_cnt <= r_stop_cnt + 2'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.tx_o      = r_tx;
  assign bus.tx_busy_o = r_busy;
  assign bus.tx_done_o = r_done;

endmodule
`default_nettype wire
